retire_unit: RTL
================

# retire_unit

In-order retirement consumer on the commit side of the reorder buffer. It accepts up to ISSUE_W registered commit slots per cycle and maintains the committed (architectural) rename table. It returns superseded physical registers to the free list, signals store drain, and queues branch-predictor training through a small FIFO. On a committed exception it raises a flush and then replays the committed table into the speculative rename map.

## Interface
- ISSUE_W, core_pkg::ISSUE_WIDTH (2): commit slots per cycle; slot 0 is oldest.
- PREG_W, $bits(core_pkg::preg_tag_t) (6): physical tag width; must be ≥5.
- BPQ_DEPTH, 4: branch-update FIFO entries; power of two.
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- commit_valid, commit_exception, commit_is_store, commit_is_branch, commit_branch_taken, commit_branch_is_call, commit_branch_is_return  in  ISSUE_W  per-slot commit flags.
- commit_arch_rd  in  5×ISSUE_W  architectural destination; 31 = XZR, no write.
- commit_phys_rd  in  PREG_W×ISSUE_W  physical destination.
- commit_pc, commit_branch_target  in  32×ISSUE_W  PC and resolved target.
- free_en  out  ISSUE_W  pulse that returns free_preg[k] to the free list.
- free_preg  out  PREG_W×ISSUE_W  superseded mapping.
- store_commit_en  out  ISSUE_W  pulse that releases the oldest store in the store buffer (slot order).
- bp_upd_valid  out  1  head of the branch FIFO is valid.
- bp_upd_ready  in  1  predictor accepts the head.
- bp_upd_pc, bp_upd_target  out  32  payload of the head entry.
- bp_upd_taken, bp_upd_is_call, bp_upd_is_return  out  1  payload of the head entry.
- bp_drop_cnt  out  16  saturating count of updates dropped because the FIFO was full.
- flush_req  out  1  one-cycle pulse on a committed exception.
- exc_pc  out  32  PC of the excepting instruction; held until the next exception.
- rat_restore_en  out  1  replay beat valid.
- rat_restore_arch  out  5  architectural register of the beat.
- rat_restore_preg  out  PREG_W  committed mapping of the beat.
- busy  out  1  high while in FLUSH or RECOVER.
- retired_cnt  out  32  wrapping count of retired non-exception instructions.

## Operation
- Committed RAT is 32 entries × PREG_W. On reset, entry i = i.
- Slot k is effective when commit_valid[k]=1, no lower slot has commit_exception=1, and the FSM is IDLE.
- For an effective, non-excepting slot with arch_rd≠31:
  - free_preg[k] = the current mapping of arch_rd; free_en[k]=1.
  - RAT[arch_rd] ← phys_rd.
- Intra-bundle bypass: if an older effective slot j<k wrote the same arch_rd, free_preg[k] = commit_phys_rd[j], not the table value. The final RAT value is the youngest writer.
- A store on an effective, non-excepting slot sets store_commit_en[k].
- A branch on an effective, non-excepting slot enqueues {pc, target, taken, call, return} in slot order.
  - Free space is computed before this cycle's dequeue.
  - Entries beyond the free space are dropped; bp_drop_cnt adds the number dropped and saturates at 0xFFFF.
  - Dequeue happens when bp_upd_valid && bp_upd_ready. The payload is the FIFO head, combinational from storage.
- An effective slot with commit_exception=1 performs no RAT, free, store or branch action. It captures exc_pc and moves the FSM to FLUSH.
- retired_cnt adds the number of effective non-excepting slots each cycle.
- FSM:
  - IDLE: normal retirement; exception → FLUSH.
  - FLUSH (1 cycle): flush_req=1; → RECOVER with the replay index at 0.
  - RECOVER (32 cycles): rat_restore_en=1, arch = index, preg = RAT[index]; index increments; after index 31 → IDLE.
  - All commit inputs are ignored in FLUSH and RECOVER.
- The branch FIFO keeps draining in every state. Already-queued entries are not discarded on a flush.

## Timing
- Reset values: every pulse output and bp_upd_valid = 0; free_preg, bp payload, exc_pc, rat_restore_* = 0; bp_drop_cnt = 0; retired_cnt = 0; busy = 0; FSM = IDLE; FIFO empty.
- reset_n asserted mid-RECOVER aborts the replay immediately and restores the identity RAT.
- Commit sampled in cycle N:
  - free_*, store_commit_en, the RAT update and retired_cnt become visible in N+1 (registered).
  - A FIFO entry enqueued at edge N+1 is presented on bp_upd_* in N+1.
- Exception in cycle N: flush_req is high in N+1; restore beats run from N+2 through N+33; first IDLE cycle is N+34.
- busy is high from N+1 through N+33.
- FIFO pointers wrap modulo BPQ_DEPTH. A full/empty ambiguity is resolved with an extra pointer bit.

## Test plan
- Post-reset: commit slot0 {arch 3, phys 40} → next cycle free_en=01, free_preg[0]=3; a later commit to arch 3 frees 40.
- Bypass: slot0 {arch 5, phys 41} and slot1 {arch 5, phys 42} in the same cycle → free_preg = {5, 41}; the restore later reports arch 5 → 42.
- XZR and store: slot0 {arch 31, is_store} → free_en=00, store_commit_en=01, retired_cnt +1.
- Exception: slot0 exception with pc 0x100, slot1 a valid store → no store pulse; flush_req in N+1; exc_pc=0x100; 32 restore beats arch 0..31; busy deasserts at N+34; inputs during busy are ignored.
- Branch overflow: bp_upd_ready=0, commit 5 branches over 3 cycles with BPQ_DEPTH=4 → 4 queued, bp_drop_cnt=1; raising ready drains them in commit order.
- Async reset asserted during RECOVER → all outputs return to reset values within the same cycle; afterwards the RAT is identity.

Source files
------------

// File: rtl/retire_unit.sv
// retire_unit: in-order retirement stage on the commit side of the reorder buffer.
//
// Consumes up to ISSUE_W commit slots per cycle (slot 0 oldest). It keeps the
// committed (architectural) rename table and returns superseded physical tags
// to the free list. It pulses store drain and queues branch-predictor updates
// in a small FIFO. A committed exception raises a one-cycle flush, then
// replays the committed table (32 beats) into the speculative rename map.
//
// Ports
//   clk, reset_n                 clock, asynchronous active-low reset
//   commit_*                     per-slot commit bundle (flags, arch/phys dest, pc, target)
//   free_en / free_preg          registered per-slot free-list return
//   store_commit_en              registered per-slot store release pulse
//   bp_upd_*                     head of the branch update FIFO (valid/ready)
//   bp_drop_cnt                  saturating count of updates lost to a full FIFO
//   flush_req, exc_pc            flush pulse and PC of the excepting instruction
//   rat_restore_*                committed-table replay beats
//   busy                         high during FLUSH and RECOVER
//   retired_cnt                  wrapping count of retired instructions
//   state_dbg                    current FSM state (0 IDLE, 1 FLUSH, 2 RECOVER)
//
// Handshake: a branch update transfers on a rising edge where bp_upd_valid and
// bp_upd_ready are both high; valid never drops without a transfer, and the
// payload stays stable while valid is high and ready is low.
module retire_unit #(
    parameter int ISSUE_W   = 2,
    parameter int PREG_W    = 6,
    parameter int BPQ_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [ISSUE_W-1:0]             commit_valid,
    input  logic [ISSUE_W-1:0]             commit_exception,
    input  logic [ISSUE_W-1:0]             commit_is_store,
    input  logic [ISSUE_W-1:0]             commit_is_branch,
    input  logic [ISSUE_W-1:0]             commit_branch_taken,
    input  logic [ISSUE_W-1:0]             commit_branch_is_call,
    input  logic [ISSUE_W-1:0]             commit_branch_is_return,
    input  logic [ISSUE_W-1:0][4:0]        commit_arch_rd,
    input  logic [ISSUE_W-1:0][PREG_W-1:0] commit_phys_rd,
    input  logic [ISSUE_W-1:0][31:0]       commit_pc,
    input  logic [ISSUE_W-1:0][31:0]       commit_branch_target,
    output logic [ISSUE_W-1:0]             free_en,
    output logic [ISSUE_W-1:0][PREG_W-1:0] free_preg,
    output logic [ISSUE_W-1:0]             store_commit_en,
    output logic                           bp_upd_valid,
    input  logic                           bp_upd_ready,
    output logic [31:0]                    bp_upd_pc,
    output logic [31:0]                    bp_upd_target,
    output logic                           bp_upd_taken,
    output logic                           bp_upd_is_call,
    output logic                           bp_upd_is_return,
    output logic [15:0]                    bp_drop_cnt,
    output logic                           flush_req,
    output logic [31:0]                    exc_pc,
    output logic                           rat_restore_en,
    output logic [4:0]                     rat_restore_arch,
    output logic [PREG_W-1:0]              rat_restore_preg,
    output logic                           busy,
    output logic [31:0]                    retired_cnt,
    output logic [1:0]                     state_dbg
);

    localparam int PTR_W = $clog2(BPQ_DEPTH) + 1;
    localparam int IDX_W = $clog2(BPQ_DEPTH);
    localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(BPQ_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FLUSH   = 2'd1,
        S_RECOVER = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic [4:0] restore_idx;

    logic [PREG_W-1:0] rat [32];

    // Branch FIFO: pointers carry one extra bit so full and empty differ.
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [31:0]      q_pc     [BPQ_DEPTH];
    logic [31:0]      q_target [BPQ_DEPTH];
    logic             q_taken  [BPQ_DEPTH];
    logic             q_call   [BPQ_DEPTH];
    logic             q_ret    [BPQ_DEPTH];

    // Per-slot decode
    logic [ISSUE_W-1:0]             eff, act, wr, st, br;
    logic [ISSUE_W-1:0][PREG_W-1:0] fp;
    logic                           exc_seen, exc_take;
    logic [31:0]                    exc_pc_nxt;
    logic [31:0]                    n_ret;

    // Enqueue decode
    logic [PTR_W-1:0]               q_cnt, q_free, n_acc;
    logic [15:0]                    n_drop;
    logic [ISSUE_W-1:0]             enq_en;
    logic [ISSUE_W-1:0][PTR_W-1:0]  enq_ptr;
    logic                           deq;
    logic [16:0]                    drop_sum;

    always_comb begin
        eff        = '0;
        act        = '0;
        wr         = '0;
        st         = '0;
        br         = '0;
        fp         = '0;
        exc_seen   = 1'b0;
        exc_take   = 1'b0;
        exc_pc_nxt = exc_pc;
        n_ret      = '0;
        for (int k = 0; k < ISSUE_W; k++) begin
            // Younger slots behind an excepting slot never retire.
            eff[k] = commit_valid[k] && !exc_seen && (state == S_IDLE);
            act[k] = eff[k] && !commit_exception[k];
            if (eff[k] && commit_exception[k]) begin
                exc_take   = 1'b1;
                exc_pc_nxt = commit_pc[k];
            end
            exc_seen = exc_seen || (commit_valid[k] && commit_exception[k]);
            wr[k] = act[k] && (commit_arch_rd[k] != 5'd31);
            st[k] = act[k] && commit_is_store[k];
            br[k] = act[k] && commit_is_branch[k];
            // Superseded tag: youngest older writer of the same arch reg wins
            // over the table value.
            fp[k] = rat[commit_arch_rd[k]];
            for (int j = 0; j < k; j++) begin
                if (wr[j] && (commit_arch_rd[j] == commit_arch_rd[k])) begin
                    fp[k] = commit_phys_rd[j];
                end
            end
            n_ret = n_ret + 32'(act[k]);
        end
    end

    always_comb begin
        // Free space uses the occupancy before this cycle's dequeue.
        q_cnt   = wr_ptr - rd_ptr;
        q_free  = DEPTH_P - q_cnt;
        n_acc   = '0;
        n_drop  = '0;
        enq_en  = '0;
        enq_ptr = '0;
        for (int k = 0; k < ISSUE_W; k++) begin
            enq_ptr[k] = wr_ptr + n_acc;
            if (br[k]) begin
                if (n_acc < q_free) begin
                    enq_en[k] = 1'b1;
                    n_acc     = n_acc + PTR_W'(1);
                end else begin
                    n_drop = n_drop + 16'd1;
                end
            end
        end
        deq      = bp_upd_valid && bp_upd_ready;
        drop_sum = {1'b0, bp_drop_cnt} + {1'b0, n_drop};
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (exc_take) state_nxt = S_FLUSH;
            S_FLUSH:   state_nxt = S_RECOVER;
            S_RECOVER: if (restore_idx == 5'd31) state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        flush_req        = (state == S_FLUSH);
        busy             = (state != S_IDLE);
        rat_restore_en   = (state == S_RECOVER);
        rat_restore_arch = rat_restore_en ? restore_idx : 5'd0;
        rat_restore_preg = rat_restore_en ? rat[restore_idx] : '0;
        state_dbg        = state;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) begin
                rat[i] <= PREG_W'(i);
            end
            free_en         <= '0;
            free_preg       <= '0;
            store_commit_en <= '0;
            retired_cnt     <= '0;
            exc_pc          <= '0;
            bp_drop_cnt     <= '0;
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            restore_idx     <= '0;
        end else begin
            // Later slots overwrite earlier ones: youngest writer wins.
            for (int k = 0; k < ISSUE_W; k++) begin
                if (wr[k]) begin
                    rat[commit_arch_rd[k]] <= commit_phys_rd[k];
                end
                free_preg[k] <= wr[k] ? fp[k] : '0;
            end
            free_en         <= wr;
            store_commit_en <= st;
            retired_cnt     <= retired_cnt + n_ret;
            exc_pc          <= exc_pc_nxt;
            bp_drop_cnt     <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
            wr_ptr          <= wr_ptr + n_acc;
            rd_ptr          <= rd_ptr + PTR_W'(deq);
            if (state == S_FLUSH) begin
                restore_idx <= 5'd0;
            end else if (state == S_RECOVER) begin
                restore_idx <= restore_idx + 5'd1;
            end
        end
    end

    // FIFO storage needs no reset: the head payload is gated by valid.
    always_ff @(posedge clk) begin
        for (int k = 0; k < ISSUE_W; k++) begin
            if (enq_en[k]) begin
                q_pc[enq_ptr[k][IDX_W-1:0]]     <= commit_pc[k];
                q_target[enq_ptr[k][IDX_W-1:0]] <= commit_branch_target[k];
                q_taken[enq_ptr[k][IDX_W-1:0]]  <= commit_branch_taken[k];
                q_call[enq_ptr[k][IDX_W-1:0]]   <= commit_branch_is_call[k];
                q_ret[enq_ptr[k][IDX_W-1:0]]    <= commit_branch_is_return[k];
            end
        end
    end

    always_comb begin
        bp_upd_valid     = (wr_ptr != rd_ptr);
        bp_upd_pc        = bp_upd_valid ? q_pc[rd_ptr[IDX_W-1:0]]     : 32'd0;
        bp_upd_target    = bp_upd_valid ? q_target[rd_ptr[IDX_W-1:0]] : 32'd0;
        bp_upd_taken     = bp_upd_valid && q_taken[rd_ptr[IDX_W-1:0]];
        bp_upd_is_call   = bp_upd_valid && q_call[rd_ptr[IDX_W-1:0]];
        bp_upd_is_return = bp_upd_valid && q_ret[rd_ptr[IDX_W-1:0]];
    end

endmodule
